// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions: round/index sizing, controller state encoding,
// and the initial hash value consumed by the compression datapath.
package sha_pkg;

    localparam int unsigned SHA_IDX_W  = 6;
    localparam int unsigned SHA_MSG_W  = 512;
    localparam int unsigned SHA_ROUNDS = 64;

    // Round controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    // H0..H7, H0 in the most significant word.
    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha_round_ctrl.sv
// SHA-256 block sequencer. Accepts one padded block over valid/ready, holds
// it for the message scheduler, steps the word index 0..ROUNDS-1, and issues
// compression round enables one cycle later to match the scheduler's
// registered output.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_valid / o_ready          block handshake
//   i_msg, i_first             block payload and first-of-message flag
//   i_abort                    drop the block in progress
//   o_msg                      latched block for the scheduler
//   o_msg_schdl_en, o_blk_nmbr scheduler enable and word index
//   o_wv_load, o_wv_from_iv    working-variable load (from IV or hash)
//   o_rnd_en, o_rnd_idx        compression round enable and K index
//   o_hash_upd, o_done         end-of-block hash update / completion pulse
//   o_busy                     controller not idle
module sha_round_ctrl
    import sha_pkg::*;
#(
    parameter int unsigned BLK_CNT = SHA_IDX_W,
    parameter int unsigned MSG_SIZ = SHA_MSG_W,
    parameter int unsigned ROUNDS  = SHA_ROUNDS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [MSG_SIZ-1:0] i_msg,
    input  logic               i_first,
    input  logic               i_abort,
    output logic [MSG_SIZ-1:0] o_msg,
    output logic               o_msg_schdl_en,
    output logic [BLK_CNT-1:0] o_blk_nmbr,
    output logic               o_wv_load,
    output logic               o_wv_from_iv,
    output logic               o_rnd_en,
    output logic [BLK_CNT-1:0] o_rnd_idx,
    output logic               o_hash_upd,
    output logic               o_done,
    output logic               o_busy
);

    localparam logic [BLK_CNT-1:0] LAST_IDX = BLK_CNT'(ROUNDS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [BLK_CNT-1:0] cnt;
    logic [BLK_CNT-1:0] cnt_nxt;
    logic               hs;

    // Word index doubles as the scheduler index output.
    assign o_blk_nmbr = cnt;

    // Next state and counter.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hs        = (state == ST_IDLE) && o_ready && i_valid;
        case (state)
            ST_IDLE: begin
                if (hs) begin
                    state_nxt = ST_ROUND;
                    cnt_nxt   = '0;
                end
            end
            ST_ROUND: begin
                if (i_abort) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == LAST_IDX) begin
                    // Index parks at the last round; it never wraps.
                    state_nxt = ST_DRAIN;
                end else begin
                    cnt_nxt = BLK_CNT'(cnt + 1'b1);
                end
            end
            ST_DRAIN: begin
                state_nxt = i_abort ? ST_IDLE : ST_UPDATE;
            end
            ST_UPDATE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            o_ready        <= 1'b0;
            o_busy         <= 1'b0;
            o_msg          <= '0;
            o_msg_schdl_en <= 1'b0;
            o_wv_load      <= 1'b0;
            o_wv_from_iv   <= 1'b0;
            o_rnd_en       <= 1'b0;
            o_rnd_idx      <= '0;
            o_hash_upd     <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            o_ready        <= (state_nxt == ST_IDLE);
            o_busy         <= (state_nxt != ST_IDLE);
            o_msg_schdl_en <= (state_nxt == ST_ROUND);
            // Load pulse coincides with the first ROUND cycle (cnt == 0).
            o_wv_load      <= hs;
            o_wv_from_iv   <= hs && i_first;
            // Round stage trails the scheduler by one cycle; abort kills it at once.
            o_rnd_en       <= (state == ST_ROUND) && !i_abort;
            o_rnd_idx      <= cnt;
            o_hash_upd     <= (state_nxt == ST_UPDATE);
            o_done         <= (state_nxt == ST_UPDATE);
            if (hs) begin
                o_msg <= i_msg;
            end
        end
    end

endmodule
